imem_loader: RTL and testbench

- Byte-stream program loader that writes the rv32i_core instruction memory.
- Holds the core in reset until the image is loaded, then releases it.
- Replaces hierarchical preloading of instruction memory for boot and FPGA flows.
- Sits between a byte source (UART receiver or bench driver) and the instruction-memory write port, and drives the core's reset_n.

---
 rtl/imem_loader.sv | 172 +++++++++++++++++
 tb/tb_imem_loader.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Byte-stream loader for the rv32i_core instruction memory: holds the core in reset until the image is written.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing modulo-256 checksum byte after the image.
module imem_loader #(
  parameter int ADDR_W     = 10,
  parameter int DEPTH      = 1024,
  parameter int BASE_WADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              core_reset_n,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CSUM = 3'd3,
`endif
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;

  localparam logic [31:0]       DEPTH_L = 32'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE_WADDR);

  state_t            state;
  logic [1:0]        byte_cnt;
  logic [23:0]       shift;
  logic [31:0]       len;
  logic [31:0]       wcnt;
  logic [ADDR_W-1:0] widx;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        sum;
`endif

  logic        xfer;
  logic [31:0] word_in;
  logic        last_word;

  // Bytes arrive little-endian, so each new byte lands in the top lane.
  assign xfer      = s_valid && s_ready;
  assign word_in   = {s_data, shift};
  assign last_word = (wcnt + 32'd1 == len);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      s_ready      <= 1'b0;
      mem_we       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      core_reset_n <= 1'b0;
      mem_waddr    <= BASE_A;
      mem_wdata    <= '0;
      byte_cnt     <= '0;
      shift        <= '0;
      len          <= '0;
      wcnt         <= '0;
      widx         <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum          <= '0;
`endif
    end else begin
      mem_we       <= 1'b0;
      // Release trails DONE by one cycle so the final write settles first.
      core_reset_n <= (state == DONE);
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state    <= LEN;
            s_ready  <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
            byte_cnt <= '0;
            shift    <= '0;
            len      <= '0;
            wcnt     <= '0;
            widx     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum      <= '0;
`endif
          end
        end
        LEN: begin
          if (xfer) begin
            byte_cnt <= byte_cnt + 2'd1;
            shift    <= word_in[31:8];
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum      <= sum + s_data;
`endif
            if (byte_cnt == 2'd3) begin
              len <= word_in;
              if (word_in == 32'd0) begin
                state   <= DONE;
                s_ready <= 1'b0;
                busy    <= 1'b0;
                done    <= 1'b1;
              end else if (word_in > DEPTH_L) begin
                state   <= ERR;
                s_ready <= 1'b0;
                busy    <= 1'b0;
                error   <= 1'b1;
              end else begin
                state <= DATA;
              end
            end
          end
        end
        DATA: begin
          if (xfer) begin
            byte_cnt <= byte_cnt + 2'd1;
            shift    <= word_in[31:8];
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum      <= sum + s_data;
`endif
            if (byte_cnt == 2'd3) begin
              mem_we    <= 1'b1;
              mem_wdata <= word_in;
              mem_waddr <= BASE_A + widx;
              widx      <= widx + 1'b1;
              wcnt      <= wcnt + 32'd1;
              if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state <= CSUM;
`else
                state   <= DONE;
                s_ready <= 1'b0;
                busy    <= 1'b0;
                done    <= 1'b1;
`endif
              end
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM: begin
          if (xfer) begin
            s_ready <= 1'b0;
            busy    <= 1'b0;
            if (s_data == sum) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state   <= IDLE;
          s_ready <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: random and directed images against a byte-level reference model.
// Covers the IMEM_LOADER_CHECKSUM_EN build as well when that macro is defined.
module tb_imem_loader;
  localparam int ADDR_W     = 10;
  localparam int DEPTH      = 1024;
  localparam int BASE_WADDR = 0;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [7:0]        s_data;
  logic              s_valid;
  logic              s_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic              core_reset_n;
  logic              busy;
  logic              done;
  logic              error;

  int checks = 0;
  int passed = 0;

  logic [7:0]        img[$];
  logic [ADDR_W-1:0] got_addr[$];
  logic [31:0]       got_data[$];

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_WADDR(BASE_WADDR)) dut (
    .clk(clk), .reset(reset), .start(start), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .core_reset_n(core_reset_n), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      got_addr.push_back(mem_waddr);
      got_data.push_back(mem_wdata);
    end
  end

  task automatic finish_image();
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] n;
    logic [7:0]  s;
    n = {img[3], img[2], img[1], img[0]};
    if (n != 0 && n <= DEPTH) begin
      s = 8'h00;
      foreach (img[i]) s = s + img[i];
      img.push_back(s);
    end
`endif
  endtask

  task automatic build_nominal();
    img = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h08, 8'hD0, 8'h05};
    finish_image();
  endtask

  task automatic build_random(input int n);
    logic [31:0] nn;
    nn = n;
    img.delete();
    for (int i = 0; i < 4; i++) img.push_back(nn[8*i +: 8]);
    for (int i = 0; i < 4 * n; i++) img.push_back(8'($urandom));
    finish_image();
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
    int t;
    t = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    s_data  = b;
    s_valid = 1'b1;
    while (s_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    ok = (s_ready === 1'b1);
    if (ok) @(posedge clk);
    #1 s_valid = 1'b0;
    if (!ok) begin
      checks++;
      $display("FAIL send_byte: s_ready stayed %b for 50 cycles, required 1", s_ready);
    end
  endtask

  // Reference: the image is decoded from its bytes alone; expected writes are plain little-endian words.
  task automatic load_and_verify(input string name, input int gmin, input int gmax, input bit mid_start);
    logic [31:0]       n;
    logic [31:0]       exp_w;
    logic [ADDR_W-1:0] exp_a;
    int                nwords;
    int                nsend;
    bit                exp_ok;
    bit                ok;
    n      = {img[3], img[2], img[1], img[0]};
    exp_ok = (n <= DEPTH);
    nwords = (n != 0 && n <= DEPTH) ? int'(n) : 0;
    nsend  = 4 + 4 * nwords;
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (nwords > 0) begin
      logic [7:0] s;
      s = 8'h00;
      for (int i = 0; i < nsend; i++) s = s + img[i];
      exp_ok = (img[nsend] == s);
      nsend++;
    end
`endif
    got_addr.delete();
    got_data.delete();
    pulse_start();
    for (int i = 0; i < nsend; i++) begin
      if (mid_start && i == 5) pulse_start();
      send_byte(img[i], $urandom_range(gmax, gmin), ok);
      if (!ok) break;
    end
    @(negedge clk);
    checks++;
    if (done !== exp_ok) $display("FAIL %s done: got %b required %b", name, done, exp_ok);
    else passed++;
    checks++;
    if (error !== !exp_ok) $display("FAIL %s error: got %b required %b", name, error, !exp_ok);
    else passed++;
    checks++;
    if (busy !== 1'b0 || s_ready !== 1'b0)
      $display("FAIL %s busy/s_ready: got %b/%b required 0/0", name, busy, s_ready);
    else passed++;
    checks++;
    if (core_reset_n !== 1'b0) $display("FAIL %s core_reset_n early: got %b required 0", name, core_reset_n);
    else passed++;
    @(negedge clk);
    checks++;
    if (core_reset_n !== exp_ok) $display("FAIL %s core_reset_n: got %b required %b", name, core_reset_n, exp_ok);
    else passed++;
    checks++;
    if (error !== !exp_ok) $display("FAIL %s error sticky: got %b required %b", name, error, !exp_ok);
    else passed++;
    checks++;
    if (got_data.size() != nwords)
      $display("FAIL %s write count: got %0d required %0d", name, got_data.size(), nwords);
    else passed++;
    for (int i = 0; i < nwords && i < got_data.size(); i++) begin
      exp_a = ADDR_W'((BASE_WADDR + i) % (1 << ADDR_W));
      exp_w = {img[4 + 4 * i + 3], img[4 + 4 * i + 2], img[4 + 4 * i + 1], img[4 + 4 * i]};
      checks++;
      if (got_addr[i] !== exp_a || got_data[i] !== exp_w)
        $display("FAIL %s write %0d: got %h@%h required %h@%h", name, i, got_data[i], got_addr[i], exp_w, exp_a);
      else passed++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; s_valid = 1'b0; s_data = 8'h00;
    repeat (2) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if ({s_ready, mem_we, busy, done, error, core_reset_n} !== 6'b0)
      $display("FAIL reset flags: got %b required 000000", {s_ready, mem_we, busy, done, error, core_reset_n});
    else passed++;
    checks++;
    if (mem_waddr !== ADDR_W'(BASE_WADDR) || mem_wdata !== 32'h0)
      $display("FAIL reset mem: got %h@%h required 00000000@%h", mem_wdata, mem_waddr, ADDR_W'(BASE_WADDR));
    else passed++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_nominal();
    build_nominal();
    load_and_verify("nominal", 0, 0, 1'b0);
    checks++;
    if (got_data.size() < 2) $display("FAIL nominal words: got %0d required 2", got_data.size());
    else if (got_addr[0] !== 0 || got_data[0] !== 32'h00000513 || got_addr[1] !== 1 || got_data[1] !== 32'h05D00893)
      $display("FAIL nominal values: got %h@%h %h@%h required 00000513@000 05d00893@001",
               got_data[0], got_addr[0], got_data[1], got_addr[1]);
    else passed++;
  endtask

  task automatic test_zero_len();
    img = '{8'h00, 8'h00, 8'h00, 8'h00};
    load_and_verify("zero_len", 0, 1, 1'b0);
  endtask

  task automatic test_oversize();
    img = '{8'h01, 8'h04, 8'h00, 8'h00};
    load_and_verify("oversize", 0, 0, 1'b0);
    pulse_start();
    checks++;
    if (s_ready !== 1'b1 || busy !== 1'b1 || error !== 1'b0)
      $display("FAIL oversize restart: got ready/busy/error %b%b%b required 110", s_ready, busy, error);
    else passed++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_max_len();
    build_random(DEPTH);
    load_and_verify("max_len", 0, 0, 1'b0);
  endtask

  task automatic test_stall();
    build_nominal();
    load_and_verify("stall", 3, 3, 1'b0);
  endtask

  task automatic test_reset_midload();
    bit ok;
    build_nominal();
    got_addr.delete();
    got_data.delete();
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(img[i], 0, ok);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    checks++;
    if ({s_ready, mem_we, busy, done, error, core_reset_n} !== 6'b0 || got_data.size() != 0)
      $display("FAIL reset_mid flags: got %b writes %0d required 000000 writes 0",
               {s_ready, mem_we, busy, done, error, core_reset_n}, got_data.size());
    else passed++;
    load_and_verify("reload", 0, 1, 1'b0);
    checks++;
    if (got_addr.size() == 0 || got_addr[0] !== ADDR_W'(BASE_WADDR))
      $display("FAIL reload first addr: got %0d writes required first at %h", got_addr.size(), ADDR_W'(BASE_WADDR));
    else passed++;
  endtask

  task automatic test_back_to_back();
    build_random(3);
    load_and_verify("busy_start", 0, 1, 1'b1);
    pulse_start();
    checks++;
    if (done !== 1'b0 || busy !== 1'b1 || s_ready !== 1'b1 || core_reset_n !== 1'b1)
      $display("FAIL restart: got done/busy/ready/crn %b%b%b%b required 0111", done, busy, s_ready, core_reset_n);
    else passed++;
    @(negedge clk);
    checks++;
    if (core_reset_n !== 1'b0) $display("FAIL restart core_reset_n: got %b required 0", core_reset_n);
    else passed++;
    build_random(2);
    load_and_verify("back_to_back", 0, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      build_random($urandom_range(6, 1));
      load_and_verify("random", 0, 2, 1'b0);
    end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    build_nominal();
    load_and_verify("csum_good", 0, 0, 1'b0);
    build_nominal();
    img[img.size() - 1] = img[img.size() - 1] + 8'd1;
    load_and_verify("csum_bad", 0, 0, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_nominal();
    test_zero_len();
    test_oversize();
    test_stall();
    test_reset_midload();
    test_back_to_back();
    test_random();
    test_max_len();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
